fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the ID-stage controller. It owns the PC and issues one request at a time to a variable-latency instruction memory. It delivers the fetched instruction and PC+4 to ID. It honours hazard stalls and accepts PC redirects from the ID-stage jump decode and the MEM-stage BEQ/BNE resolution.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction fetch (PC, one-deep imem handshake) plus the IF/ID pipeline register.
// Latency: request in cycle N, response earliest N+1, instruction valid in IF/ID at N+2.
// Backpressure: stall freezes PC and IF/ID; a response arriving under stall parks in a hold buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        j_redirect,
  input  logic [31:0] j_target,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        inst_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  // One fetched word together with the PC+4 of the instruction it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } fetch_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc;
  logic        discard, discard_nxt;
  fetch_t      hold_q, hold_nxt;
  fetch_t      ifid_q, ifid_nxt;
  logic        ifid_vld, ifid_vld_nxt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        load;
  fetch_t      load_dat;

  // Requests are a pure decode of registered state so no input reaches imem_req/imem_addr.
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst       = ifid_q.inst;
  assign pc_plus4   = ifid_q.pc_plus4;
  assign inst_valid = ifid_vld;

  // Next-state, PC and IF/ID selection; a redirect overrides stall and kills the old path.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    discard_nxt     = discard;
    hold_nxt        = hold_q;
    load            = 1'b0;
    load_dat        = '0;
    ifid_nxt        = ifid_q;
    ifid_vld_nxt    = ifid_vld;
    pc_inc          = pc + 32'd4;
    redirect        = br_redirect | j_redirect;
    // Branch resolves later in the pipe than the jump, so it is the older instruction and wins.
    redirect_target = (br_redirect ? br_target : j_target) & 32'hFFFF_FFFC;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        state_nxt = WAIT;
        // The request to the old pc still goes out; its data must be thrown away.
        if (redirect) discard_nxt = 1'b1;
      end
      WAIT: begin
        if (!imem_rvalid) begin
          if (redirect) discard_nxt = 1'b1;
        end else if (discard || redirect) begin
          discard_nxt = 1'b0;
          state_nxt   = REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_dat  = '{inst: imem_rdata, pc_plus4: pc_inc};
          pc_nxt    = pc_inc;
          state_nxt = REQ;
        end else begin
          hold_nxt  = '{inst: imem_rdata, pc_plus4: pc_inc};
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Leaving HOLD on a redirect is what invalidates the parked word.
        if (redirect) begin
          state_nxt = REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_dat  = hold_q;
          pc_nxt    = pc_inc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect) pc_nxt = redirect_target;

    if (redirect) begin
      ifid_nxt     = '0;
      ifid_vld_nxt = 1'b0;
    end else if (load) begin
      ifid_nxt     = load_dat;
      ifid_vld_nxt = 1'b1;
    end else if (!stall) begin
      ifid_nxt     = '0;
      ifid_vld_nxt = 1'b0;
    end
  end

  // State, PC, discard flag, hold buffer and IF/ID registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      hold_q   <= '0;
      ifid_q   <= '0;
      ifid_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      discard  <= discard_nxt;
      hold_q   <= hold_nxt;
      ifid_q   <= ifid_nxt;
      ifid_vld <= ifid_vld_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: randomized and directed check of fetch_stage against a transaction-level model.
// Latency: model predicts outputs each cycle; imem responder uses 1..4 cycle latency.
// Backpressure: stall and redirects are driven randomly and in directed sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        j_redirect;
  logic [31:0] j_target;
  logic        br_redirect;
  logic [31:0] br_target;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        inst_valid;

  // Second instance exercising the PC wrap from the top of the address space.
  logic        w_rst_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_zero;
  logic [31:0] w_zero32;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic        w_vld;
  bit          wrap_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall),
    .j_redirect(j_redirect), .j_target(j_target),
    .br_redirect(br_redirect), .br_target(br_target),
    .inst(inst), .pc_plus4(pc_plus4), .inst_valid(inst_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .stall(w_zero),
    .j_redirect(w_zero), .j_target(w_zero32),
    .br_redirect(w_zero), .br_target(w_zero32),
    .inst(w_inst), .pc_plus4(w_pc4), .inst_valid(w_vld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: pending request, outstanding request, stale flag, parked words, expected IF/ID.
  logic [31:0] m_pc;
  bit          m_issue, m_out, m_stale, m_started;
  logic [63:0] m_held[$];
  logic [31:0] m_inst, m_pc4;
  bit          m_vld;

  // Instruction memory responder state.
  int          mem_cnt;
  int          force_lat;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_issue   = 1'b0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_started = 1'b0;
    m_held.delete();
    m_inst    = 32'h0;
    m_pc4     = 32'h0;
    m_vld     = 1'b0;
  endtask

  // One cycle: compare at negedge, run memory, drive inputs, advance the model to the next edge.
  task automatic step(input bit st, input bit jr, input logic [31:0] jt,
                      input bit br, input logic [31:0] bt, input bit rst);
    logic [31:0] tgt, rd;
    logic [63:0] d;
    bit          redir, deliver, nissue, rv;
    @(negedge clk);
    chk("imem_req",   32'(imem_req),   32'(m_issue));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("inst",       inst,            m_inst);
    chk("pc_plus4",   pc_plus4,        m_pc4);
    chk("inst_valid", 32'(inst_valid), 32'(m_vld));

    rv = 1'b0;
    rd = 32'h0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_word(mem_addr);
      end
    end
    if (imem_req) begin
      mem_addr = imem_addr;
      mem_cnt  = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
    end

    imem_rvalid = rv;
    imem_rdata  = rv ? rd : $urandom();
    stall       = st;
    j_redirect  = jr;
    j_target    = jt;
    br_redirect = br;
    br_target   = bt;
    rst_n       = !rst;

    if (rst) begin
      model_reset();
    end else begin
      redir   = br | jr;
      tgt     = (br ? bt : jt) & 32'hFFFF_FFFC;
      deliver = 1'b0;
      nissue  = 1'b0;
      d       = 64'h0;
      if (!m_started) begin
        m_started = 1'b1;
        nissue    = 1'b1;
      end else begin
        if (m_out && rv) begin
          m_out = 1'b0;
          if (m_stale || redir) nissue = 1'b1;
          else if (st) m_held.push_back({rd, m_pc + 32'd4});
          else begin
            deliver = 1'b1;
            d       = {rd, m_pc + 32'd4};
            nissue  = 1'b1;
          end
          m_stale = 1'b0;
        end else if (m_held.size() != 0) begin
          if (redir) begin
            m_held.delete();
            nissue = 1'b1;
          end else if (!st) begin
            deliver = 1'b1;
            d       = m_held.pop_front();
            nissue  = 1'b1;
          end
        end else if (m_out && redir) begin
          m_stale = 1'b1;
        end
        if (m_issue) begin
          m_out   = 1'b1;
          m_stale = redir;
        end
      end
      if (redir) begin
        m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
      end else if (deliver) begin
        m_inst = d[63:32]; m_pc4 = d[31:0]; m_vld = 1'b1;
      end else if (!st) begin
        m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
      end
      if (redir) m_pc = tgt;
      else if (deliver) m_pc = m_pc + 32'd4;
      m_issue = nissue;
    end
  endtask

  task automatic step0();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Wrap instance: reset PC at the top of memory, first PC+4 must wrap to zero.
  initial begin
    bit found;
    w_rst_n   = 1'b0;
    w_rvalid  = 1'b0;
    w_rdata   = 32'h0;
    w_zero    = 1'b0;
    w_zero32  = 32'h0;
    wrap_done = 1'b0;
    found     = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_reset_req",  32'(w_req), 32'h0);
    w_rst_n = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (w_req) found = 1'b1;
    end
    chk("wrap_req_seen", 32'(found), 32'h1);
    chk("wrap_req_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rvalid = 1'b1;
    w_rdata  = 32'h2402_0007;
    @(negedge clk);
    w_rvalid = 1'b0;
    chk("wrap_inst",      w_inst, 32'h2402_0007);
    chk("wrap_pc_plus4",  w_pc4,  32'h0000_0000);
    chk("wrap_valid",     32'(w_vld), 32'h1);
    chk("wrap_next_req",  32'(w_req), 32'h1);
    chk("wrap_next_addr", w_addr, 32'h0000_0000);
    wrap_done = 1'b1;
  end

  // Main sequence: directed scenarios with literal expectations, then randomized traffic.
  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    j_redirect  = 1'b0;
    j_target    = 32'h0;
    br_redirect = 1'b0;
    br_target   = 32'h0;
    mem_cnt     = 0;
    force_lat   = 1;
    model_reset();

    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);

    step0();                                   // release reset
    step0();
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step0();
    chk("req_one_cycle", 32'(imem_req), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("first_inst", inst, 32'h8C01_0004);
    chk("first_pc4", pc_plus4, 32'h4);
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("second_addr", imem_addr, 32'h4);

    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("stall_hold1", inst, 32'h8C01_0004);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("stall_hold2", inst, 32'h8C01_0004);
    step0();
    chk("stall_hold3", inst, 32'h8C01_0004);
    chk("hold_no_req", 32'(imem_req), 32'h0);
    force_lat = 3;
    step0();
    chk("release_inst", inst, 32'h0);
    chk("release_pc4", pc_plus4, 32'h8);
    chk("release_valid", 32'(inst_valid), 32'h1);
    chk("release_addr", imem_addr, 32'h8);

    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
    step0();
    chk("jump_bubble", 32'(inst_valid), 32'h0);
    step0();
    force_lat = 1;
    step0();
    chk("jump_req", 32'(imem_req), 32'h1);
    chk("jump_addr", imem_addr, 32'h40);
    chk("jump_dropped", 32'(inst_valid), 32'h0);
    step0();
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100, 1'b0);
    chk("jump_inst", inst, mem_word(32'h40));
    chk("jump_pc4", pc_plus4, 32'h44);
    chk("jump_valid", 32'(inst_valid), 32'h1);
    step0();
    chk("both_bubble", 32'(inst_valid), 32'h0);
    force_lat = 3;
    step0();
    chk("br_priority_addr", imem_addr, 32'h100);
    chk("br_priority_req", 32'(imem_req), 32'h1);

    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);  // reset while in WAIT
    step0();
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", 32'(inst_valid), 32'h0);
    force_lat = 2;
    step0();
    chk("restart_req", 32'(imem_req), 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    step0();
    chk("late_ignored", 32'(inst_valid), 32'h0);
    step0();
    step0();
    chk("restart_inst", inst, 32'h8C01_0004);
    chk("restart_pc4", pc_plus4, 32'h4);

    force_lat = 0;
    repeat (3000) begin
      step($urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 6, $urandom(),
           $urandom_range(0, 99) < 4, $urandom(), 1'b0);
    end

    chk("wrap_done", 32'(wrap_done), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
